// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the LPC target's write-data path and the
// UART transmitter. Host writes land here in bursts; bytes are handed to the
// transmitter one at a time as one-cycle strobes, paced by its busy flag.
// `full` replaces the raw UART busy as back-pressure to the LPC target.
//
// Ports:
//   LPC_CLK   in   sole clock, rising edge
//   LPC_RST   in   synchronous active-high reset
//   wr_data   in   [7:0] byte from the LPC target
//   wr_valid  in   one-cycle push strobe
//   tx_busy   in   transmitter busy
//   ovf_clr   in   clears the sticky overflow flag
//   tx_data   out  [7:0] byte presented to the transmitter (held until next pop)
//   tx_valid  out  one-cycle strobe to the transmitter
//   full      out  level == depth (registered)
//   empty     out  level == 0 (registered)
//   level     out  [DEPTH_LOG2:0] bytes stored, excluding the byte already issued
//   overflow  out  sticky: a push was dropped
//
// state     | meaning
// IDLE      | may issue the next byte when data is stored and tx_busy is low
// WAIT_BUSY | byte issued; waiting for tx_busy to rise, bounded by BUSY_TIMEOUT
// WAIT_IDLE | transmitter accepted the byte; waiting for tx_busy to fall
module uart_tx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  LPC_CLK,
  input  logic                  LPC_RST,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  input  logic                  tx_busy,
  input  logic                  ovf_clr,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [7:0]            TMO      = 8'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_IDLE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [7:0]            cnt, cnt_nxt;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic                  push, drop, pop;

  // Full is judged on the registered flag, so a push while full is dropped
  // even when a pop frees a slot on the same edge.
  assign push = wr_valid && !full;
  assign drop = wr_valid && full;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (level != '0 && !tx_busy) begin
          pop       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_IDLE;
        end else if (cnt == TMO) begin
          // transmitter never signalled busy; treat the byte as consumed
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      WAIT_IDLE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    level_nxt = level;
    unique case ({push, pop})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge LPC_CLK) begin
    if (LPC_RST) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      level    <= level_nxt;
      full     <= (level_nxt == LVL_FULL);
      empty    <= (level_nxt == '0);
      tx_valid <= pop;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        tx_data <= mem[rd_ptr];
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge LPC_CLK) begin
    if (push && !LPC_RST) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed scenarios plus a randomized run.
// A queue-based reference model predicts level/flags/strobes each cycle;
// accepted bytes go into a scoreboard queue that a separate monitor drains
// whenever the DUT strobes tx_valid.
module tb_uart_tx_fifo;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int TMO   = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     wr_data = 8'h00;
  logic           wr_valid = 1'b0;
  logic           tx_busy = 1'b0;
  logic           ovf_clr = 1'b0;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           full;
  logic           empty;
  logic [DL2:0]   level;
  logic           overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(DL2), .BUSY_TIMEOUT(TMO)) dut (
    .LPC_CLK (clk),
    .LPC_RST (rst),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .tx_busy (tx_busy),
    .ovf_clr (ovf_clr),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tx_left = 0;

  logic [7:0] exp_q[$];   // scoreboard: accepted bytes not yet seen on tx
  logic [7:0] mq[$];      // model FIFO contents (bytes stored, not issued)
  logic [7:0] mon_exp;

  // Model of the issue window: 0 = may issue, 1 = issued and waiting for
  // busy (gives up after TMO+1 quiet cycles), 2 = waiting for busy to fall.
  int  m_phase = 0;
  int  m_cnt   = 0;
  bit  m_valid = 1'b0;
  bit  m_ovf   = 1'b0;
  bit  m_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: check current outputs against the model, drive inputs for
  // this cycle, then advance the model to the next rising edge.
  task automatic step(input bit r, input bit wv, input logic [7:0] wd,
                      input bit busy, input bit clr);
    bit was_full;
    bit do_pop;
    @(negedge clk);
    #1;
    cyc++;
    if (m_known) begin
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_valid});
      chk("level", {27'b0, level}, mq.size());
      chk("full", {31'b0, full}, {31'b0, mq.size() == DEPTH});
      chk("empty", {31'b0, empty}, {31'b0, mq.size() == 0});
      chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    end
    rst      = r;
    wr_valid = wv;
    wr_data  = wd;
    tx_busy  = busy;
    ovf_clr  = clr;
    if (r) begin
      mq.delete();
      exp_q.delete();
      m_phase = 0;
      m_cnt   = 0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_known = 1'b1;
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = (m_phase == 0) && (mq.size() > 0) && !busy;
      if (do_pop) begin
        void'(mq.pop_front());
        m_phase = 1;
        m_cnt   = 0;
      end else if (m_phase == 1) begin
        if (busy)             m_phase = 2;
        else if (m_cnt == TMO) m_phase = 0;
        else                   m_cnt++;
      end else if (m_phase == 2) begin
        if (!busy) m_phase = 0;
      end
      if (wv && !was_full) begin
        mq.push_back(wd);
        exp_q.push_back(wd);
      end
      if (wv && was_full) m_ovf = 1'b1;
      else if (clr)       m_ovf = 1'b0;
      m_valid = do_pop;
    end
  endtask

  // Randomized traffic with a transmitter that goes busy for a random
  // 0..8 cycles after each strobe (0 exercises the busy timeout).
  task automatic run(input int n, input int push_pct, input int rst_pm, input int clr_pct);
    for (int i = 0; i < n; i++) begin
      bit b, r, wv, c;
      b  = (tx_left > 0);
      r  = (int'($urandom_range(999, 0)) < rst_pm);
      wv = (int'($urandom_range(99, 0)) < push_pct);
      c  = (int'($urandom_range(99, 0)) < clr_pct);
      step(r, wv, 8'($urandom), b, c);
      if (tx_left > 0) tx_left--;
      if (r) tx_left = 0;
      else if (tx_valid === 1'b1) tx_left = int'($urandom_range(8, 0));
    end
  endtask

  // Scoreboard monitor: runs on the falling edge, ahead of the stimulus
  // process which waits a further #1.
  initial begin
    forever begin
      @(negedge clk);
      if (m_known && tx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: strobe with data %0h, no byte expected (cycle %0d)", tx_data, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("tx_data_order", {24'b0, tx_data}, {24'b0, mon_exp});
        end
      end
    end
  end

  initial begin
    int last;
    int ns;

    // reset then idle
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    chk("rst_empty", {31'b0, empty}, 1);
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_level", {27'b0, level}, 0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h00);
    chk("rst_overflow", {31'b0, overflow}, 0);
    step(0, 0, 8'h00, 0, 0);

    // single byte, transmitter busy one cycle after the strobe for 10 cycles
    step(0, 1, 8'h41, 0, 0);                       // n
    step(0, 0, 8'h00, 0, 0);                       // n+1
    chk("single_no_early", {31'b0, tx_valid}, 0);
    step(0, 0, 8'h00, 0, 0);                       // n+2
    chk("single_strobe", {31'b0, tx_valid}, 1);
    chk("single_data", {24'b0, tx_data}, 32'h41);
    step(0, 0, 8'h00, 1, 0);                       // n+3
    chk("single_one_cycle", {31'b0, tx_valid}, 0);
    chk("single_level0", {27'b0, level}, 0);
    chk("single_hold_data", {24'b0, tx_data}, 32'h41);
    for (int i = 0; i < 9; i++) step(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 0);

    // reset mid-burst at level 5, with an issue otherwise due on that edge
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hB0 + i), 1, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("midrst_level5", {27'b0, level}, 5);
    step(1, 1, 8'hEE, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    chk("midrst_level0", {27'b0, level}, 0);
    chk("midrst_no_strobe", {31'b0, tx_valid}, 0);
    chk("midrst_empty", {31'b0, empty}, 1);
    step(0, 0, 8'h00, 0, 0);
    chk("midrst_still_quiet", {31'b0, tx_valid}, 0);

    // burst of 16 with transmitter busy, then one dropped push
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 1, 0);
    step(0, 1, 8'hAA, 1, 0);
    chk("burst_full", {31'b0, full}, 1);
    chk("burst_level16", {27'b0, level}, 16);
    step(0, 0, 8'h00, 1, 1);
    chk("burst_overflow_set", {31'b0, overflow}, 1);
    step(0, 0, 8'h00, 1, 0);
    chk("burst_overflow_clr", {31'b0, overflow}, 0);
    chk("burst_level_kept", {27'b0, level}, 16);
    tx_left = 0;
    run(300, 0, 0, 0);
    chk("burst_drained", exp_q.size(), 0);

    // second burst wraps the pointers again
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h10 + i), 1, 0);
    tx_left = 0;
    run(300, 0, 0, 0);
    chk("burst2_drained", exp_q.size(), 0);

    // simultaneous push and pop at level 3
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h70 + i), 1, 0);
    step(0, 1, 8'h77, 0, 0);
    chk("simul_pre_level3", {27'b0, level}, 3);
    step(0, 0, 8'h00, 1, 0);
    chk("simul_level3", {27'b0, level}, 3);
    chk("simul_strobe", {31'b0, tx_valid}, 1);
    tx_left = 0;
    run(200, 0, 0, 0);

    // busy stuck low: each byte released by the timeout
    last = -1;
    ns   = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, i < 3, 8'(8'h60 + i), 0, 0);
      if (tx_valid === 1'b1) begin
        if (last >= 0) chk("timeout_gap", cyc - last, TMO + 2);
        last = cyc;
        ns++;
      end
    end
    chk("timeout_strobes", ns, 3);

    // push while full coinciding with a pop; overflow set beats ovf_clr
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'hC0 + i), 1, 0);
    step(0, 1, 8'h55, 0, 1);
    step(0, 0, 8'h00, 1, 0);
    chk("fullpop_overflow", {31'b0, overflow}, 1);
    chk("fullpop_level15", {27'b0, level}, 15);
    chk("fullpop_strobe", {31'b0, tx_valid}, 1);
    step(0, 0, 8'h00, 1, 1);
    tx_left = 0;
    run(300, 0, 0, 0);

    // randomized traffic with occasional clears and resets
    run(3000, 55, 2, 5);
    tx_left = 0;
    run(400, 0, 0, 0);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_level0", {27'b0, level}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
